wb_rtsnoc_bridge: RTL

Parametrised Wishbone-slave to RTSNoC bridge, successor of the single-mode bridge. It turns each Wishbone classic cycle into command/data packets toward one fixed NoC target. It waits for a status packet (OK/ERR, plus data for reads) and terminates the cycle with `wb_ack_o` or `wb_err_o`. A response timeout, byte-select forwarding and source filtering of incoming packets are the generational additions.

---
 rtl/rtsnoc_pkg.sv | 41 ++++
 rtl/wb_rtsnoc_bridge_rx.sv | 79 +++++++
 rtl/wb_rtsnoc_bridge.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rtsnoc_pkg.sv
// +----------------------------------------------------------------------+
// | rtsnoc_pkg -- RTSNoC packet type codes and flit field geometry        |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package rtsnoc_pkg;

  typedef enum logic [2:0] {
    PKT_WRITE = 3'd0,
    PKT_READ  = 3'd1,
    PKT_INT   = 3'd2,
    PKT_ERR   = 3'd3,
    PKT_OK    = 3'd4
  } pkt_type_e;

  localparam int PKT_TYPE_W  = 3;
  localparam int PKT_SEL_W   = 4;
  localparam int NOC_LOCAL_W = 3;

  // One router address: {X, Y, local}
  function automatic int noc_hdr_w(input int sx, input int sy);
    return sx + sy + NOC_LOCAL_W;
  endfunction

  // Flit = {origin addr, destination addr, payload}
  function automatic int noc_bus_size(input int dw, input int sx, input int sy);
    return dw + 2 * noc_hdr_w(sx, sy);
  endfunction

  function automatic int noc_dst_lsb(input int dw);
    return dw;
  endfunction

  function automatic int noc_org_lsb(input int dw, input int sx, input int sy);
    return dw + noc_hdr_w(sx, sy);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_rtsnoc_bridge_rx.sv
// +----------------------------------------------------------------------+
// | wb_rtsnoc_rx -- RX flit capture, origin filter and interrupt detect    |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module wb_rtsnoc_rx
  import rtsnoc_pkg::*;
#(
  parameter int DW         = 32,
  parameter int SX         = 1,
  parameter int SY         = 1,
  parameter int LOCAL_TGT  = 0,
  parameter int X_TGT      = 0,
  parameter int Y_TGT      = 0,
  localparam int BUS       = noc_bus_size(DW, SX, SY)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [BUS-1:0] noc_dout_i,
  input  logic           noc_nd_i,
  output logic           noc_rd_o,
  output logic           noc_int_o,
  output logic           rsp_valid_o,
  output logic [2:0]     rsp_type_o,
  output logic [DW-1:0]  rsp_data_o
);

  localparam int HW      = noc_hdr_w(SX, SY);
  localparam int ORG_LSB = noc_org_lsb(DW, SX, SY);
  localparam int DST_LSB = noc_dst_lsb(DW);
  localparam logic [HW-1:0] ACCEPT_ORG =
    {SX'(X_TGT), SY'(Y_TGT), NOC_LOCAL_W'(LOCAL_TGT)};

  logic              rd_q, rd_d;
  logic [HW-1:0]     org_q, org_d;
  logic [DW-1:0]     pay_q, pay_d;
  logic              org_ok;
  logic              int_clean;
  logic [HW-1:0]     dst_unused;

  assign dst_unused = noc_dout_i[DST_LSB +: HW];

  // One read strobe per flit: the strobe itself blocks the next capture.
  always_comb begin
    rd_d  = noc_nd_i & ~rd_q;
    org_d = org_q;
    pay_d = pay_q;
    if (rd_d) begin
      org_d = noc_dout_i[ORG_LSB +: HW];
      pay_d = noc_dout_i[DW-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q  <= 1'b0;
      org_q <= '0;
      pay_q <= '0;
    end else begin
      rd_q  <= rd_d;
      org_q <= org_d;
      pay_q <= pay_d;
    end
  end

  assign org_ok    = (org_q == ACCEPT_ORG);
  assign int_clean = (pay_q[DW-1 -: PKT_TYPE_W] == PKT_INT) &&
                     (pay_q[DW-PKT_TYPE_W-1:0] == '0);

  assign noc_rd_o    = rd_q;
  assign noc_int_o   = rd_q & org_ok & int_clean;
  assign rsp_valid_o = rd_q & org_ok & ~int_clean;
  assign rsp_type_o  = pay_q[DW-1 -: PKT_TYPE_W];
  assign rsp_data_o  = pay_q;

endmodule

`default_nettype wire

// File: rtl/wb_rtsnoc_bridge.sv
// +----------------------------------------------------------------------+
// | wb_rtsnoc_bridge -- Wishbone classic slave to RTSNoC command bridge    |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module wb_rtsnoc_bridge
  import rtsnoc_pkg::*;
#(
  parameter int WB_ADDR_WIDTH     = 6,
  parameter int WB_NOC_DATA_WIDTH = 32,
  parameter int NOC_LOCAL_ADR     = 0,
  parameter int NOC_X             = 0,
  parameter int NOC_Y             = 0,
  parameter int NOC_LOCAL_ADR_TGT = 0,
  parameter int NOC_X_TGT         = 0,
  parameter int NOC_Y_TGT         = 0,
  parameter int SOC_SIZE_X        = 1,
  parameter int SOC_SIZE_Y        = 1,
  parameter int WRITE_ACK         = 0,
  parameter int TIMEOUT_CYCLES    = 1024,
  localparam int NOC_BUS_SIZE     = noc_bus_size(WB_NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  input  logic                         wb_we_i,
  input  logic [WB_ADDR_WIDTH-1:0]     wb_adr_i,
  input  logic [3:0]                   wb_sel_i,
  input  logic [WB_NOC_DATA_WIDTH-1:0] wb_dat_i,
  output logic [WB_NOC_DATA_WIDTH-1:0] wb_dat_o,
  output logic                         wb_ack_o,
  output logic                         wb_err_o,
  output logic                         noc_int_o,
  output logic [NOC_BUS_SIZE-1:0]      noc_din_o,
  output logic                         noc_wr_o,
  output logic                         noc_rd_o,
  input  logic [NOC_BUS_SIZE-1:0]      noc_dout_i,
  input  logic                         noc_wait_i,
  input  logic                         noc_nd_i
);

  localparam int DW = WB_NOC_DATA_WIDTH;
  localparam int HW = noc_hdr_w(SOC_SIZE_X, SOC_SIZE_Y);
  localparam logic [2*HW-1:0] TX_HDR = {
    SOC_SIZE_X'(NOC_X),     SOC_SIZE_Y'(NOC_Y),     NOC_LOCAL_W'(NOC_LOCAL_ADR),
    SOC_SIZE_X'(NOC_X_TGT), SOC_SIZE_Y'(NOC_Y_TGT), NOC_LOCAL_W'(NOC_LOCAL_ADR_TGT)
  };

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TX_CMD    = 3'd1,
    S_TX_DATA   = 3'd2,
    S_WAIT_RSP  = 3'd3,
    S_WAIT_DATA = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [NOC_BUS_SIZE-1:0] din_q, din_d;
  logic                    wr_q, wr_d;
  logic [DW-1:0]           dat_q, dat_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    we_q, we_d;
  logic                    done_err_q, done_err_d;
  logic [DW-1:0]           cmd_payload;
  logic                    timeout_hit;

  logic                    rsp_valid;
  logic [2:0]              rsp_type;
  logic [DW-1:0]           rsp_data;

  wb_rtsnoc_rx #(
    .DW        (DW),
    .SX        (SOC_SIZE_X),
    .SY        (SOC_SIZE_Y),
    .LOCAL_TGT (NOC_LOCAL_ADR_TGT),
    .X_TGT     (NOC_X_TGT),
    .Y_TGT     (NOC_Y_TGT)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .noc_dout_i  (noc_dout_i),
    .noc_nd_i    (noc_nd_i),
    .noc_rd_o    (noc_rd_o),
    .noc_int_o   (noc_int_o),
    .rsp_valid_o (rsp_valid),
    .rsp_type_o  (rsp_type),
    .rsp_data_o  (rsp_data)
  );

  // Command payload: {type, sel, zero fill, word address}
  always_comb begin
    cmd_payload = '0;
    cmd_payload[DW-1 -: PKT_TYPE_W] = wb_we_i ? PKT_WRITE : PKT_READ;
    cmd_payload[DW-PKT_TYPE_W-1 -: PKT_SEL_W] = wb_sel_i;
    cmd_payload[WB_ADDR_WIDTH-1:0] = wb_adr_i;
  end

  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    wr_d       = 1'b0;
    dat_d      = dat_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    we_d       = we_q;
    done_err_d = done_err_q;
    case (state_q)
      S_IDLE: begin
        // The ack/err cycle still sees the old stb, so it must not restart.
        if (wb_cyc_i && wb_stb_i && !ack_q && !err_q) begin
          din_d   = {TX_HDR, cmd_payload};
          wr_d    = 1'b1;
          we_d    = wb_we_i;
          state_d = S_TX_CMD;
        end
      end
      S_TX_CMD: begin
        if (!noc_wait_i) begin
          if (we_q) begin
            din_d   = {TX_HDR, wb_dat_i};
            wr_d    = 1'b1;
            state_d = S_TX_DATA;
          end else begin
            state_d = S_WAIT_RSP;
          end
        end
      end
      S_TX_DATA: begin
        if (!noc_wait_i) begin
          if (WRITE_ACK != 0) begin
            state_d = S_WAIT_RSP;
          end else begin
            done_err_d = 1'b0;
            state_d    = S_DONE;
          end
        end
      end
      S_WAIT_RSP: begin
        if (rsp_valid && rsp_type == PKT_OK) begin
          if (we_q) begin
            done_err_d = 1'b0;
            state_d    = S_DONE;
          end else begin
            state_d = S_WAIT_DATA;
          end
        end else if ((rsp_valid && rsp_type == PKT_ERR) || timeout_hit) begin
          done_err_d = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_WAIT_DATA: begin
        if (rsp_valid) begin
          dat_d      = rsp_data;
          done_err_d = 1'b0;
          state_d    = S_DONE;
        end else if (timeout_hit) begin
          done_err_d = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        ack_d   = ~done_err_q;
        err_d   = done_err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      din_q      <= '0;
      wr_q       <= 1'b0;
      dat_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      din_q      <= din_d;
      wr_q       <= wr_d;
      dat_q      <= dat_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      we_q       <= we_d;
      done_err_q <= done_err_d;
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if ((state_d == S_WAIT_RSP || state_d == S_WAIT_DATA) && state_d != state_q) begin
          cnt_d = '0;
        end else if (state_q == S_WAIT_RSP || state_q == S_WAIT_DATA) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end

      assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign noc_din_o = din_q;
  assign noc_wr_o  = wr_q;

endmodule

`default_nettype wire
